// File: rtl/asip_pkg.sv
// Shared definitions for the ASIP front end: instruction/PC widths, the bubble
// encoding, opcode field position and the IF/ID record handed to decode.
package asip_pkg;

  localparam int INSTR_W = 24;
  localparam int PC_W    = 16;

  // Opcode lives in the top nibble of every instruction.
  localparam int OPC_MSB = INSTR_W - 1;
  localparam int OPC_LSB = INSTR_W - 4;

  // Opcode 4'b1110 is side-effect free in decode: no mem/reg/PC write.
  localparam logic [3:0]         OPC_NOP   = 4'b1110;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 24'hE00000;

  localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 16'h0000;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
    logic               valid;
  } if_id_t;

  // Extract the opcode field of an instruction word.
  function automatic logic [3:0] get_opcode(input logic [INSTR_W-1:0] instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction

  // IF/ID record for a squashed slot; the PC field is carried through unchanged.
  function automatic if_id_t make_bubble(input logic [PC_W-1:0] pc);
    if_id_t b;
    b.instr = NOP_INSTR;
    b.pc    = pc;
    b.valid = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/fetch_pc_gen.sv
// PC generator for the fetch stage: owns the next sequential PC, the address
// currently in flight in the synchronous ROM, and the ROM address mux.
// A redirect overrides everything; a stall replays the in-flight address so
// the ROM output stays aligned with req_pc_q without any skid buffer.
module fetch_pc_gen
  import asip_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic            branch_taken_i,
  input  logic [PC_W-1:0] branch_target_i,
  output logic [PC_W-1:0] imem_addr_o,
  output logic [PC_W-1:0] req_pc_o,
  output logic            req_valid_o
);

  logic [PC_W-1:0] next_pc_q;
  logic [PC_W-1:0] req_pc_q;
  logic            req_valid_q;

  // ROM address: redirect target, replayed request on stall, else sequential PC.
  always_comb begin
    if (branch_taken_i) begin
      imem_addr_o = branch_target_i;
    end else if (stall_i) begin
      imem_addr_o = req_pc_q;
    end else begin
      imem_addr_o = next_pc_q;
    end
  end

  // PC / in-flight request state, priority rst > branch > flush > stall > advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      next_pc_q   <= RESET_PC;
      req_pc_q    <= RESET_PC;
      req_valid_q <= 1'b0;
    end else if (branch_taken_i) begin
      req_pc_q    <= branch_target_i;
      req_valid_q <= 1'b1;
      next_pc_q   <= branch_target_i + 16'd1;
    end else if (flush_i) begin
      // The fetch issued this cycle is squashed, but the PC keeps walking.
      req_pc_q    <= next_pc_q;
      req_valid_q <= 1'b0;
      next_pc_q   <= next_pc_q + 16'd1;
    end else if (stall_i) begin
      req_pc_q    <= req_pc_q;
      req_valid_q <= req_valid_q;
      next_pc_q   <= next_pc_q;
    end else begin
      req_pc_q    <= next_pc_q;
      req_valid_q <= 1'b1;
      next_pc_q   <= next_pc_q + 16'd1;
    end
  end

  assign req_pc_o    = req_pc_q;
  assign req_valid_o = req_valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register feeding decode.
// Optional feature macro: FETCH_PERF_CNT_EN adds fetch_cnt_o / bubble_cnt_o
// performance counters; without it the core behaviour is identical.
// Any slot presented with valid_o=0 always carries NOP_INSTR so decode
// stays free of side effects.
module fetch_stage
  import asip_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_i,
  input  logic               flush_i,
  input  logic               branch_taken_i,
  input  logic [PC_W-1:0]    branch_target_i,
  output logic [PC_W-1:0]    imem_addr_o,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  output logic [INSTR_W-1:0] instruction_o,
  output logic [PC_W-1:0]    pc_o,
  output logic               valid_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        fetch_cnt_o,
  output logic [31:0]        bubble_cnt_o
`endif
);

  logic [PC_W-1:0] req_pc;
  logic            req_valid;
  if_id_t          if_id_q;
  if_id_t          if_id_d;
  logic            if_id_load;

  fetch_pc_gen #(
    .RESET_PC(RESET_PC)
  ) u_pc_gen (
    .clk            (clk),
    .rst            (rst),
    .stall_i        (stall_i),
    .flush_i        (flush_i),
    .branch_taken_i (branch_taken_i),
    .branch_target_i(branch_target_i),
    .imem_addr_o    (imem_addr_o),
    .req_pc_o       (req_pc),
    .req_valid_o    (req_valid)
  );

  // Next IF/ID contents; a redirect or flush squashes the slot even under stall.
  always_comb begin
    if_id_d    = if_id_q;
    if_id_load = 1'b0;
    if (branch_taken_i || flush_i) begin
      if_id_d    = make_bubble(if_id_q.pc);
      if_id_load = 1'b1;
    end else if (stall_i) begin
      if_id_d    = if_id_q;
      if_id_load = 1'b0;
    end else if (req_valid) begin
      if_id_d.instr = imem_rdata_i;
      if_id_d.pc    = req_pc;
      if_id_d.valid = 1'b1;
      if_id_load    = 1'b1;
    end else begin
      // Squashed request: ROM data is stale, substitute the bubble encoding.
      if_id_d    = make_bubble(req_pc);
      if_id_load = 1'b1;
    end
  end

  // IF/ID pipeline register toward decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_id_q <= make_bubble(16'h0000);
    end else begin
      if_id_q <= if_id_d;
    end
  end

  assign instruction_o = if_id_q.instr;
  assign pc_o          = if_id_q.pc;
  assign valid_o       = if_id_q.valid;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] bubble_cnt_q;

  // Count IF/ID loads of real instructions and of bubbles; both hold while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q  <= 32'd0;
      bubble_cnt_q <= 32'd0;
    end else if (if_id_load && if_id_d.valid) begin
      fetch_cnt_q  <= fetch_cnt_q + 32'd1;
      bubble_cnt_q <= bubble_cnt_q;
    end else if (if_id_load) begin
      fetch_cnt_q  <= fetch_cnt_q;
      bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end else begin
      fetch_cnt_q  <= fetch_cnt_q;
      bubble_cnt_q <= bubble_cnt_q;
    end
  end

  assign fetch_cnt_o  = fetch_cnt_q;
  assign bubble_cnt_o = bubble_cnt_q;
`endif

endmodule
